// File: rtl/ctrl_alu_pipe.sv
// ctrl_alu_pipe: decode / register-read / execute stage with scoreboard,
// iterative MUL, valid/ready on both sides and external writeback port.
// Ports:
//   clk, reset           clock, async active-high reset
//   in_valid/in_ready    instruction handshake, instruction = word
//   wb_en/wb_reg/wb_data register file writeback from downstream
//   out_valid/out_ready  result handshake
//   out_op/out_result/out_store_data/out_regD/out_zero/out_illegal  result
module ctrl_alu_pipe #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic            wb_en,
    input  logic [4:0]      wb_reg,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_op,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_regD,
    output logic            out_zero,
    output logic            out_illegal
);

    localparam logic [6:0] OP_ADD = 7'h00;
    localparam logic [6:0] OP_SUB = 7'h01;
    localparam logic [6:0] OP_MUL = 7'h02;
    localparam logic [6:0] OP_LDB = 7'h10;
    localparam logic [6:0] OP_LDW = 7'h11;
    localparam logic [6:0] OP_STB = 7'h12;
    localparam logic [6:0] OP_STW = 7'h13;
    localparam logic [6:0] OP_BEQ = 7'h30;

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mul_a, mul_b, prod;
    logic [4:0]      mul_rd;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pend, pend_nxt;

    logic [6:0]      op;
    logic [4:0]      dst, s1, s2;
    logic [XLEN-1:0] off_x, rs1, rs2, rsd;
    logic            is_mul, writer, use_s2, use_d, illegal;
    logic            hazard, accept, mul_done, mul_start, load_now;
    logic [XLEN-1:0] nxt_res, nxt_sd;
    logic            nxt_zero;

    function automatic logic in_rng(input logic [4:0] i);
        return 32'(i) < NREGS;
    endfunction

    // Register read with write-through bypass of the same-cycle writeback.
    function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] i);
        if (!in_rng(i))
            return '0;
        else if (wb_en && wb_reg == i)
            return wb_data;
        else
            return regs[i];
    endfunction

    // Pending unless the writeback in this very cycle clears it.
    function automatic logic busy_reg(input logic [4:0] i);
        return in_rng(i) && pend[i] && !(wb_en && wb_reg == i);
    endfunction

    assign op    = instruction[31:25];
    assign dst   = instruction[24:20];
    assign s1    = instruction[19:15];
    assign s2    = instruction[14:10];
    assign off_x = {{(XLEN-15){instruction[14]}}, instruction[14:0]};
    assign rs1   = rd_reg(s1);
    assign rs2   = rd_reg(s2);
    assign rsd   = rd_reg(dst);
    assign prod  = mul_a * mul_b;

    always_comb begin
        nxt_res  = '0;
        nxt_sd   = '0;
        nxt_zero = 1'b0;
        is_mul   = 1'b0;
        writer   = 1'b0;
        use_s2   = 1'b0;
        use_d    = 1'b0;
        illegal  = 1'b0;
        unique case (op)
            OP_ADD: begin
                nxt_res = rs1 + rs2;
                writer  = 1'b1;
                use_s2  = 1'b1;
            end
            OP_SUB: begin
                nxt_res = rs1 - rs2;
                writer  = 1'b1;
                use_s2  = 1'b1;
            end
            OP_MUL: begin
                // Only a single-cycle MUL completes from this path.
                nxt_res = (MUL_CYCLES == 1) ? rs1 * rs2 : '0;
                is_mul  = 1'b1;
                writer  = 1'b1;
                use_s2  = 1'b1;
            end
            OP_LDB, OP_LDW: begin
                nxt_res = rs1 + off_x;
                writer  = 1'b1;
            end
            OP_STB, OP_STW: begin
                nxt_res = rs1 + off_x;
                nxt_sd  = rsd;
                use_d   = 1'b1;
            end
            OP_BEQ: begin
                nxt_res  = off_x;
                nxt_zero = (rsd == rs1);
                use_d    = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (op == OP_ADD || op == OP_SUB || op == OP_MUL)
            nxt_zero = (nxt_res == '0);
    end

    assign hazard = !illegal &&
                    (busy_reg(s1) ||
                     (use_s2 && busy_reg(s2)) ||
                     ((use_d || writer) && busy_reg(dst)));

    assign in_ready  = !reset && state == IDLE && !hazard &&
                       (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul && (MUL_CYCLES > 1);
    assign mul_done  = state == MUL_BUSY && cnt == CW'(1);
    assign load_now  = accept && !mul_start;

    // Set wins over a same-cycle clear of the same register.
    always_comb begin
        pend_nxt = pend;
        if (wb_en && in_rng(wb_reg))
            pend_nxt[wb_reg] = 1'b0;
        if (accept && writer && in_rng(dst))
            pend_nxt[dst] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            mul_a          <= '0;
            mul_b          <= '0;
            mul_rd         <= '0;
            pend           <= '0;
            out_valid      <= 1'b0;
            out_op         <= '0;
            out_result     <= '0;
            out_store_data <= '0;
            out_regD       <= '0;
            out_zero       <= 1'b0;
            out_illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            pend <= pend_nxt;
            if (wb_en && in_rng(wb_reg))
                regs[wb_reg] <= wb_data;

            unique case (state)
                IDLE: begin
                    if (mul_start) begin
                        state  <= MUL_BUSY;
                        cnt    <= CW'(MUL_CYCLES - 1);
                        mul_a  <= rs1;
                        mul_b  <= rs2;
                        mul_rd <= dst;
                    end
                end
                MUL_BUSY: begin
                    if (cnt == CW'(1))
                        state <= IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase

            if (mul_done) begin
                out_valid      <= 1'b1;
                out_op         <= OP_MUL;
                out_result     <= prod;
                out_store_data <= '0;
                out_regD       <= mul_rd;
                out_zero       <= (prod == '0);
                out_illegal    <= 1'b0;
            end else if (load_now) begin
                out_valid      <= 1'b1;
                out_op         <= op;
                out_result     <= nxt_res;
                out_store_data <= nxt_sd;
                out_regD       <= dst;
                out_zero       <= nxt_zero;
                out_illegal    <= illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_alu_pipe.sv
// tb_ctrl_alu_pipe: directed vector table plus hand sequences for
// hazard bypass, output backpressure and reset during MUL.
module tb_ctrl_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_op;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_regD;
    logic        out_zero;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    ctrl_alu_pipe #(.XLEN(32), .NREGS(32), .MUL_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_result(out_result),
        .out_store_data(out_store_data), .out_regD(out_regD),
        .out_zero(out_zero), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          lat;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        zero;
        logic        ill;
        logic        wr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        @(posedge clk); #1;
        wb_en = 1'b1; wb_reg = r; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    // Offers ins until accepted, then returns at the negedge where
    // out_valid is seen; lat counts edges from accept edge inclusive.
    task automatic issue(input logic [31:0] ins, output int lat);
        bit got;
        got = 0;
        lat = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; instruction = ins;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int   lat;
        bit   seen;

        vecs.push_back('{"add",     32'h0030_8800, 1, 32'd8,         0, 3,  0, 0, 1});
        vecs.push_back('{"sub0",    32'h0290_8400, 1, 32'd0,         0, 9,  1, 0, 1});
        vecs.push_back('{"subneg",  32'h02A1_0400, 1, 32'hFFFF_FFFE, 0, 10, 0, 0, 1});
        vecs.push_back('{"addwrap", 32'h00B3_0400, 1, 32'd4,         0, 11, 0, 0, 1});
        vecs.push_back('{"addzero", 32'h00C3_9C00, 1, 32'd0,         0, 12, 1, 0, 1});
        vecs.push_back('{"ldw",     32'h2200_8050, 1, 32'd85,        0, 0,  0, 0, 1});
        vecs.push_back('{"ldb",     32'h2000_FFF0, 1, 32'hFFFF_FFF5, 0, 0,  0, 0, 1});
        vecs.push_back('{"stw",     32'h2620_8004, 1, 32'd9,         3, 2,  0, 0, 0});
        vecs.push_back('{"stb",     32'h2450_C000, 1, 32'hFFFF_C005, 7, 5,  0, 0, 0});
        vecs.push_back('{"beqne",   32'h6050_8010, 1, 32'h10,        0, 5,  0, 0, 0});
        vecs.push_back('{"beqeq",   32'h6010_FFFF, 1, 32'hFFFF_FFFF, 0, 1,  1, 0, 0});
        vecs.push_back('{"mul",     32'h04D0_8800, 4, 32'd15,        0, 13, 0, 0, 1});
        vecs.push_back('{"mulneg",  32'h04E3_0800, 4, 32'hFFFF_FFFD, 0, 14, 0, 0, 1});
        vecs.push_back('{"mulzero", 32'h04F4_8400, 4, 32'd0,         0, 15, 1, 0, 1});
        vecs.push_back('{"illegal", 32'hFF10_0000, 1, 32'd0,         0, 17, 0, 1, 0});

        reset = 1'b1; in_valid = 1'b0; instruction = '0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        wb(1, 5);
        wb(2, 3);
        wb(5, 7);
        wb(6, 32'hFFFF_FFFF);
        wb(7, 32'h8000_0000);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            issue(v.ins, lat);
            chk({v.name, "_lat"}, lat, v.lat);
            chk({v.name, "_result"}, out_result, v.res);
            chk({v.name, "_sdata"}, out_store_data, v.sd);
            chk({v.name, "_regD"}, {27'd0, out_regD}, {27'd0, v.rd});
            chk({v.name, "_flags"}, {out_zero, out_illegal},
                {v.zero, v.ill});
            chk({v.name, "_op"}, {25'd0, out_op}, {25'd0, v.ins[31:25]});
            if (v.wr) wb(v.rd, v.res);
        end

        // RAW stall on r3, released by same-cycle writeback bypass.
        issue(32'h0030_8800, lat);
        chk("raw_first", out_result, 8);
        @(posedge clk); #1;
        in_valid = 1'b1; instruction = 32'h0041_8400;
        @(negedge clk);
        chk("raw_stall1", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("raw_stall2", in_ready, 0);
        @(posedge clk); #1;
        wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'd20;
        @(negedge clk);
        chk("raw_bypass_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        chk("raw_out_valid", out_valid, 1);
        chk("raw_bypass_result", out_result, 25);
        wb(4, 25);

        // Output backpressure, then back-to-back at full rate.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'h0100_8800;
        @(negedge clk);
        chk("bp_accept", in_ready, 1);
        @(posedge clk); #1;
        instruction = 32'h0120_8400;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", out_result, 8);
            chk("bp_hold_regD", {27'd0, out_regD}, 16);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_result", out_result, 10);
        chk("b2b_regD", {27'd0, out_regD}, 18);
        wb(16, 8);
        wb(18, 10);

        // MUL busy, then reset before it completes.
        @(posedge clk); #1;
        in_valid = 1'b1; instruction = 32'h0540_8800;
        @(negedge clk);
        chk("mul_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mul_busy1_ready", in_ready, 0);
        chk("mul_busy1_valid", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mul_busy2_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("mrst_no_result", seen, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; instruction = 32'h0140_8800;
        @(negedge clk);
        chk("mrst_sb_clear", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_regs_valid", out_valid, 1);
        chk("mrst_regs_zero", out_result, 0);
        chk("mrst_zero_flag", out_zero, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_alu_pipe.md
Name: ctrl_alu_pipe

Overview:
- Parametrised decode/register-read/execute stage; successor to the single-cycle control-to-ALU datapath.
- Decodes 32-bit instructions (opcode [31:25], dst [24:20], src1 [19:15], src2 [14:10], offset [14:0]) and reads an internal register file.
- Executes ADD/SUB, iterative MUL, load/store address generation, and BEQ compare.
- Valid/ready on both sides, a register scoreboard for RAW/WAW stalls, and an external writeback port from the downstream memory/writeback stage.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of registers (≤32; register fields are 5 bits; indices ≥NREGS read 0 and are never written).
- MUL_CYCLES, 4, MUL latency in cycles from accept to out_valid (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage accepts instruction this cycle.
- instruction  in  32  instruction word.
- wb_en  in  1  register writeback strobe.
- wb_reg  in  5  writeback register index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  execute result valid.
- out_ready  in  1  downstream accepts result.
- out_op  out  7  opcode of result.
- out_result  out  XLEN  ALU result or effective address, or sign-extended branch offset for BEQ.
- out_store_data  out  XLEN  reg[dst] for stores.
- out_regD  out  5  destination register.
- out_zero  out  1  zero / equal flag.
- out_illegal  out  1  undefined opcode.

Behaviour:
- Clock and reset: single clock clk; reset asynchronous active-high.
- Reset values:
  - All out_* registers and the FSM go to 0/IDLE.
  - Scoreboard cleared; register file zeroed.
  - in_ready forced 0 while reset is high.
  - Reset mid-MUL aborts the operation; no result is produced.
- Opcodes:
  - 0x00 ADD: rs1+rs2.
  - 0x01 SUB: rs1−rs2.
  - 0x02 MUL: rs1*rs2, low XLEN bits.
  - 0x10 LDB, 0x11 LDW: rs1+sext(off).
  - 0x12 STB, 0x13 STW: addr rs1+sext(off); store data reg[dst].
  - 0x30 BEQ: zero=(reg[dst]==rs1); result=sext(off).
- Arithmetic: wraps modulo 2^XLEN. off is sign-extended from bit 14.
- out_zero: (result==0) for ADD/SUB/MUL; the BEQ compare result for BEQ; 0 for loads and stores.
- Illegal opcodes: out_illegal=1, result=0, out_valid=1, regD passed through, scoreboard not touched.
- Sources read per opcode:
  - ADD/SUB/MUL read src1, src2.
  - Loads read src1.
  - Stores and BEQ read src1 and dst.
- Writers: ADD/SUB/MUL/LDB/LDW write dst.
- Scoreboard: one pending bit per register.
  - Set at accept of a writer.
  - Cleared on wb_en for wb_reg.
  - If the same register is set and cleared in the same cycle, set wins.
- Hazard stall: in_ready=0 if any source or the writer's dst is pending, unless wb_en this cycle targets that register. in_ready may depend combinationally on instruction.
- Writeback: the register file is written at the edge when wb_en=1. A same-cycle read of wb_reg returns wb_data (write-through bypass).
- FSM states: IDLE, MUL_BUSY.
  - in_ready = IDLE && !hazard && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Non-MUL accept: out_* loaded at the accept edge; out_valid=1 the next cycle (latency 1).
  - MUL accept: operands latched, counter=MUL_CYCLES−1, go to MUL_BUSY (if MUL_CYCLES=1, complete at the same edge as a non-MUL op).
  - MUL_BUSY: counter decrements each edge; at 0 the product loads into out_*, out_valid=1, return to IDLE. out_valid rises exactly MUL_CYCLES edges after accept; in_ready=0 throughout.
- Output handshake: out_* are held stable while out_valid && !out_ready. The output slot is cleared on out_ready unless a new result loads at the same edge (back-to-back at full rate).

Test Plan:
1. Write r1=5, r2=3 via wb; ADD 0x0030_8800 -> out_valid one cycle after accept; out_result=8, out_regD=3, out_zero=0; r3 pending.
2. r1=r2=5; SUB 0x0230_8800 -> out_result=0, out_zero=1; wb r3 clears pending.
3. MUL 0x0430_8800, r1=5, r2=3, MUL_CYCLES=4 -> in_ready=0 for 4 cycles; out_valid at 4th edge after accept; out_result=15.
4. ADD r3 then ADD 0x0041_8400 (r4=r3+r1) -> in_ready=0 until wb_en r3=8; accepted in the same cycle via bypass; out_result=13.
5. r1=5: LDW 0x2200_8050 -> out_result=85; LDB with off 0x7FF0 -> out_result=−11 (0xFFFF_FFF5). STW 0x2620_8004 with r2=7, r1=5 -> out_result=9, store_data=7.
6. Hold out_ready=0 for 3 cycles -> out_* stable and in_ready=0. Then assert reset mid-MUL -> out_valid=0, scoreboard clear, in_ready=1 after release, registers read 0. Opcode 0x7F -> out_illegal=1.
